// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter register and fetch-control stage for the IF stage. Sits
// directly after the PC-select mux. It registers the selected next PC on
// execution cycles, gates updates with the hazard stall, and runs a small
// debug FSM:
//   IDLE   - waiting for the debug unit to start execution
//   RUN    - continuous execution
//   STEP   - one execution cycle per rising edge of i_step
//   HALTED - HALT decoded; frozen until restart or reset
// It also keeps a saturating count of execution cycles.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_next_pc      next PC from the PC-select mux
//   i_stall        hazard stall, holds the PC for this cycle
//   i_halt         HALT decoded at the current PC
//   i_start        leave IDLE (mode sampled with it)
//   i_mode         0 = continuous run, 1 = single step
//   i_step         step request level; one step per 0->1 edge
//   i_restart      return to IDLE with PC and counter cleared
//   o_pc           current PC (registered)
//   o_pc_plus4     o_pc + 4, combinational, wraps
//   o_pc_en        PC loads i_next_pc at the next edge (combinational)
//   o_running      registered, 1 in RUN or STEP
//   o_halted       registered, 1 in HALTED
//   o_cycle_count  executed cycles since start, saturating
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int unsigned        PC_SIZE  = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0,
    parameter int unsigned        CNT_SIZE = 32
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [PC_SIZE-1:0]  i_next_pc,
    input  logic                i_stall,
    input  logic                i_halt,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic                i_step,
    input  logic                i_restart,
    output logic [PC_SIZE-1:0]  o_pc,
    output logic [PC_SIZE-1:0]  o_pc_plus4,
    output logic                o_pc_en,
    output logic                o_running,
    output logic                o_halted,
    output logic [CNT_SIZE-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2,
        StHalted = 2'd3
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic                r_step_q;
    logic                w_step_edge;
    logic                w_exec;
    logic                w_pc_en;
    logic [PC_SIZE-1:0]  r_pc;
    logic [PC_SIZE-1:0]  w_pc_next;
    logic [CNT_SIZE-1:0] r_cycle_count;
    logic [CNT_SIZE-1:0] w_cycle_count_next;
    logic                r_running;
    logic                r_halted;

    // ------------------------------------------------------------------
    // Execution-cycle qualification
    // ------------------------------------------------------------------
    assign w_step_edge = i_step & ~r_step_q;
    assign w_exec      = (r_state == StRun) || ((r_state == StStep) && w_step_edge);

    // Halt and restart both block the PC load; halt wins over stall by
    // virtue of simply also blocking it.
    assign w_pc_en = w_exec & ~i_stall & ~i_halt & ~i_restart;

    // ------------------------------------------------------------------
    // Next-state, next-PC and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_cycle_count_next = r_cycle_count;

        if (i_restart) begin
            w_state_next       = StIdle;
            w_pc_next          = RESET_PC;
            w_cycle_count_next = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_state_next = i_mode ? StStep : StRun;
                    end
                end
                StRun, StStep: begin
                    if (w_exec && i_halt) begin
                        w_state_next = StHalted;
                    end
                end
                StHalted: begin
                    w_state_next = StHalted;
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase

            if (w_pc_en) begin
                w_pc_next = i_next_pc;
            end

            // Stalled and halting exec cycles are counted too.
            if (w_exec && !(&r_cycle_count)) begin
                w_cycle_count_next = r_cycle_count + CNT_SIZE'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_step_q      <= 1'b0;
            r_pc          <= RESET_PC;
            r_cycle_count <= '0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            // Step history tracks i_step in every state so that a level
            // held across entry into STEP does not count as an edge.
            r_step_q      <= i_step;
            r_pc          <= w_pc_next;
            r_cycle_count <= w_cycle_count_next;
            r_running     <= (w_state_next == StRun) || (w_state_next == StStep);
            r_halted      <= (w_state_next == StHalted);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + PC_SIZE'(4);
    assign o_pc_en       = w_pc_en;
    assign o_running     = r_running;
    assign o_halted      = r_halted;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed table of vectors for pc_fetch_ctrl plus hand-written sequences for
// asynchronous reset, PC+4 wrap and counter saturation (small-counter DUT).
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] next_pc;
    logic        stall, halt, start, mode, step, restart;
    logic [31:0] pc, pc_plus4, cycle_count;
    logic        pc_en, running, halted;

    // Second instance with a 3-bit counter for the saturation check.
    logic        s_start;
    logic [31:0] s_pc, s_pc_plus4;
    logic        s_pc_en, s_running, s_halted;
    logic [2:0]  s_count;

    int total = 0;
    int bad   = 0;

    pc_fetch_ctrl #(
        .PC_SIZE  (32),
        .RESET_PC (32'h0000_0000),
        .CNT_SIZE (32)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_next_pc     (next_pc),
        .i_stall       (stall),
        .i_halt        (halt),
        .i_start       (start),
        .i_mode        (mode),
        .i_step        (step),
        .i_restart     (restart),
        .o_pc          (pc),
        .o_pc_plus4    (pc_plus4),
        .o_pc_en       (pc_en),
        .o_running     (running),
        .o_halted      (halted),
        .o_cycle_count (cycle_count)
    );

    pc_fetch_ctrl #(
        .PC_SIZE  (32),
        .RESET_PC (32'h0000_0000),
        .CNT_SIZE (3)
    ) dut_sat (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_next_pc     (s_pc_plus4),
        .i_stall       (1'b0),
        .i_halt        (1'b0),
        .i_start       (s_start),
        .i_mode        (1'b0),
        .i_step        (1'b0),
        .i_restart     (1'b0),
        .o_pc          (s_pc),
        .o_pc_plus4    (s_pc_plus4),
        .o_pc_en       (s_pc_en),
        .o_running     (s_running),
        .o_halted      (s_halted),
        .o_cycle_count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        mode;
        logic        step;
        logic        stall;
        logic        halt;
        logic        restart;
        logic [31:0] next_pc;
        logic        exp_pc_en;
        logic [31:0] exp_pc;
        logic        exp_running;
        logic        exp_halted;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // st md sp sl ht rs next        en  pc       run hlt count
    task automatic add(input logic st, input logic md, input logic sp, input logic sl,
                       input logic ht, input logic rs, input logic [31:0] np,
                       input logic en, input logic [31:0] epc, input logic er,
                       input logic eh, input logic [31:0] ec);
        vec_t v;
        v.start = st; v.mode = md; v.step = sp; v.stall = sl; v.halt = ht; v.restart = rs;
        v.next_pc = np; v.exp_pc_en = en; v.exp_pc = epc; v.exp_running = er;
        v.exp_halted = eh; v.exp_count = ec;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        start = 0; mode = 0; step = 0; stall = 0; halt = 0; restart = 0;
    endtask

    initial begin
        idle_inputs();
        next_pc = 32'h0;
        s_start = 1'b0;
        reset_n = 1'b0;

        // Continuous run, stall, halt with stall
        add(1,0,0,0,0,0, 32'h04, 0, 32'h00, 1,0, 0);
        add(0,0,0,0,0,0, 32'h04, 1, 32'h04, 1,0, 1);
        add(0,0,0,0,0,0, 32'h08, 1, 32'h08, 1,0, 2);
        add(0,0,0,0,0,0, 32'h0C, 1, 32'h0C, 1,0, 3);
        add(0,0,0,1,0,0, 32'h10, 0, 32'h0C, 1,0, 4);
        add(0,0,0,1,0,0, 32'h10, 0, 32'h0C, 1,0, 5);
        add(0,0,0,0,0,0, 32'h10, 1, 32'h10, 1,0, 6);
        add(0,0,0,1,1,0, 32'h14, 0, 32'h10, 0,1, 7);
        // HALTED ignores start/step/stall
        add(1,0,1,0,0,0, 32'h14, 0, 32'h10, 0,1, 7);
        add(0,0,0,1,0,0, 32'h14, 0, 32'h10, 0,1, 7);
        add(1,1,1,0,0,0, 32'h14, 0, 32'h10, 0,1, 7);
        // Restart from HALTED
        add(0,0,0,0,0,1, 32'h14, 0, 32'h00, 0,0, 0);
        // Step mode
        add(1,1,0,0,0,0, 32'h04, 0, 32'h00, 1,0, 0);
        add(0,0,1,0,0,0, 32'h04, 1, 32'h04, 1,0, 1);
        add(0,0,1,0,0,0, 32'h08, 0, 32'h04, 1,0, 1);
        add(0,0,1,0,0,0, 32'h08, 0, 32'h04, 1,0, 1);
        add(0,0,1,0,0,0, 32'h08, 0, 32'h04, 1,0, 1);
        add(0,0,1,0,0,0, 32'h08, 0, 32'h04, 1,0, 1);
        add(0,0,0,0,1,0, 32'h08, 0, 32'h04, 1,0, 1);
        add(0,0,1,0,0,0, 32'h08, 1, 32'h08, 1,0, 2);
        add(0,0,0,0,0,0, 32'h0C, 0, 32'h08, 1,0, 2);
        add(0,0,1,1,0,0, 32'h0C, 0, 32'h08, 1,0, 3);
        add(0,0,0,0,0,0, 32'h0C, 0, 32'h08, 1,0, 3);
        add(0,0,1,0,1,0, 32'h0C, 0, 32'h08, 0,1, 4);
        // Restart, RUN, then restart with simultaneous halt/start
        add(0,0,0,0,0,1, 32'h0C, 0, 32'h00, 0,0, 0);
        add(1,0,0,0,0,0, 32'h20, 0, 32'h00, 1,0, 0);
        add(0,0,0,0,0,0, 32'h20, 1, 32'h20, 1,0, 1);
        add(1,0,0,0,1,1, 32'h24, 0, 32'h00, 0,0, 0);
        add(0,0,0,0,0,0, 32'h24, 0, 32'h00, 0,0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 32'h0);
        check("reset_plus4", pc_plus4, 32'h4);
        check("reset_running", {31'b0, running}, 32'h0);
        check("reset_halted", {31'b0, halted}, 32'h0);
        check("reset_count", cycle_count, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; mode = vecs[i].mode; step = vecs[i].step;
            stall = vecs[i].stall; halt = vecs[i].halt; restart = vecs[i].restart;
            next_pc = vecs[i].next_pc;
            #1;
            check($sformatf("v%0d_pc_en", i), {31'b0, pc_en}, {31'b0, vecs[i].exp_pc_en});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
            check($sformatf("v%0d_running", i), {31'b0, running}, {31'b0, vecs[i].exp_running});
            check($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_halted});
            check($sformatf("v%0d_count", i), cycle_count, vecs[i].exp_count);
        end
        idle_inputs();

        // Asynchronous reset mid-run at PC = 0x20
        start = 1;
        @(posedge clk); #1;
        start = 0;
        next_pc = 32'h20;
        @(posedge clk); #1;
        check("async_pre_pc", pc, 32'h20);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_running", {31'b0, running}, 32'h0);
        check("async_count", cycle_count, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // PC + 4 wrap at the top of the address space
        start = 1;
        @(posedge clk); #1;
        start = 0;
        next_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        restart = 1;
        @(posedge clk); #1;
        restart = 0;

        // 3-bit counter saturates at 7 after 10 exec cycles
        s_start = 1;
        @(posedge clk); #1;
        s_start = 0;
        repeat (10) @(posedge clk);
        #1;
        check("sat_count", {29'b0, s_count}, 32'h7);
        check("sat_pc", s_pc, 32'd40);
        check("sat_running", {31'b0, s_running}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter register and fetch-control stage that sits directly downstream of the 4-input PC-select multiplexer in the IF stage.
- Each enabled cycle, it registers the selected next PC.
- It runs a small FSM for the debug unit: idle, continuous run, single-step, halted.
- It gates PC updates with the hazard-unit stall and counts execution cycles.
- Its outputs drive instruction-memory addressing and the IF/ID latch enable.

Parameters:
PC_SIZE, 32, width of PC and next-PC buses
RESET_PC, 32'h0000_0000, PC value after reset or restart
CNT_SIZE, 32, width of cycle counter

Ports:
i_clk  input  1  system clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_next_pc  input  PC_SIZE  next PC from the PC-select mux
i_stall  input  1  hazard-unit stall; 1 = hold PC this cycle
i_halt  input  1  HALT instruction decoded at current PC
i_start  input  1  debug unit: leave IDLE
i_mode  input  1  sampled with i_start: 0 = continuous, 1 = step
i_step  input  1  debug step request, level; one step per 0->1 edge
i_restart  input  1  return to IDLE with PC and counter cleared
o_pc  output  PC_SIZE  current PC (registered)
o_pc_plus4  output  PC_SIZE  o_pc + 4, combinational, wraps mod 2^PC_SIZE
o_pc_en  output  1  combinational; 1 when PC loads i_next_pc at the next edge
o_running  output  1  registered; 1 in RUN or STEP
o_halted  output  1  registered; 1 in HALTED
o_cycle_count  output  CNT_SIZE  executed cycles since start, saturating

Behaviour:
Reset (i_reset_n = 0, asynchronous, any time including mid-run):
- State goes to IDLE.
- o_pc = RESET_PC, o_cycle_count = 0, o_running = 0, o_halted = 0.
- Step edge-detector history register = 0.
- All registered state updates on the rising edge of i_clk.

States: IDLE, RUN, STEP, HALTED.

Execution cycle ("exec"):
- exec = (state == RUN), or (state == STEP and i_step edge detected this cycle).
- Step edge = i_step & ~step_q. step_q is a register holding the previous i_step.
- o_pc_en = exec & ~i_stall & ~i_halt & ~i_restart.
- On an edge where o_pc_en = 1: o_pc <= i_next_pc.
- Every exec cycle increments o_cycle_count, stalled or not. Exception: the cycle that raises i_restart does not increment.
- o_cycle_count saturates at all-ones and never wraps.

Transitions, in priority order (i_restart highest):
- Any state, i_restart = 1 -> IDLE; o_pc = RESET_PC; o_cycle_count = 0.
- IDLE, i_start = 1 -> RUN if i_mode = 0, STEP if i_mode = 1. No exec occurs in the IDLE cycle.
- RUN/STEP, exec and i_halt = 1 -> HALTED. PC is not updated. The halting cycle is counted. i_halt wins over a simultaneous stall.
- RUN, otherwise: stay in RUN.
- STEP, otherwise: stay in STEP. No step edge means PC and counter are unchanged. A held-high i_step gives exactly one step.
- HALTED: PC and counter frozen. i_start, i_step and i_stall are ignored. Exit only via i_restart or reset.

Ignored inputs outside exec:
- i_stall and i_halt have no effect in IDLE or HALTED.
- i_halt has no effect in STEP without a step edge.

Latency:
- o_pc reflects i_next_pc one clock after the cycle in which o_pc_en = 1.
- o_pc_plus4 follows o_pc combinationally.

Test Plan:
- Reset then continuous run: RESET_PC = 0; i_start = 1, i_mode = 0 for one cycle; drive i_next_pc = o_pc_plus4 -> o_pc = 0, 4, 8, 12 on successive cycles; o_running = 1; o_cycle_count = 3 after three exec cycles.
- Stall: in RUN at PC = 8, i_stall = 1 for 2 cycles -> o_pc_en = 0 and o_pc holds 8 for 2 cycles; counter still +2; PC = 12 on the cycle after stall drops.
- Halt: at PC = 0x10 assert i_halt with i_stall = 1 -> next cycle o_halted = 1, o_running = 0, o_pc = 0x10; later i_start and i_step pulses change nothing.
- Step mode: i_start with i_mode = 1; hold i_step high for 5 cycles -> exactly one PC advance (0 -> 4) and count = 1; second 0->1 edge -> PC = 8, count = 2.
- Restart vs. simultaneous events: in RUN, assert i_restart together with i_halt and i_start -> IDLE, o_pc = RESET_PC, count = 0, o_halted = 0.
- Asynchronous reset mid-run: drop i_reset_n between clock edges at PC = 0x20 -> o_pc = RESET_PC and o_running = 0 immediately, without waiting for a clock edge. Also check o_pc = 0xFFFFFFFC gives o_pc_plus4 = 0.
